fwd_hazard_unit_p: RTL and testbench
====================================

Name: fwd_hazard_unit_p

Overview:
- Parametrised successor to the two-operand, two-stage forwarding unit.
- Tracks in-flight register writes internally in a DEPTH-entry shift register, so it does not take per-stage Rd inputs. Emits one forward select per EX source operand and a load-use stall.
- Sits beside the EX stage. Selects drive the per-operand forwarding muxes; stall_o freezes PC/IF/ID/ID-EX and tells the unit to inject a bubble.

Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction
- DEPTH, 3, forwardable stages after EX (entry 0 = EX/MEM, entry DEPTH-1 = oldest)
- LOAD_LAT, 1, extra cycles after EX/MEM before load data is forwardable; elaboration error if LOAD_LAT >= DEPTH
- CNT_W, 16, width of stall counter
- SEL_W, $clog2(DEPTH+1), derived width of each select

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX holds a real instruction
- ex_reg_write_i  in  1  EX instruction writes rd
- ex_is_load_i  in  1  EX instruction is a load
- ex_rd_i  in  REG_AW  EX destination
- ex_rs_i  in  NUM_SRC*REG_AW  EX sources, packed, source j at [j*REG_AW +: REG_AW]
- ex_rs_used_i  in  NUM_SRC  source j actually read from regfile (0 for immediate operand)
- hold_i  in  1  global pipeline freeze (e.g. memory wait)
- flush_i  in  1  EX instruction killed (branch mispredict)
- fwd_sel_o  out  NUM_SRC*SEL_W  per source: 0 = regfile, k+1 = entry k
- stall_o  out  1  load-use hazard; hold IF..ID/EX this cycle
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry fields: valid, wr, is_load, rd. An entry "matches" source j if valid & wr & rd != 0 & rd == rs_j & ex_rs_used_i[j].
- fwd_sel j (combinational):
  - youngest (lowest k) matching entry gives k+1; no match gives 0.
  - Youngest-wins is required when several entries share rd.
  - fwd_sel forced to 0 when ex_valid_i = 0.
- Hazard: the winning entry for any source has is_load=1 and k < LOAD_LAT.
  - stall_o = hazard & ex_valid_i & !flush_i.
  - fwd_sel for a hazarded source is still driven (don't-care for the top level).
- Tracker update, rising clk, priority order:
  1. rst: all entries valid=0, stall_cnt=0.
  2. hold_i: no change to entries or counter.
  3. flush_i or stall_o: shift (entry k <- entry k-1), entry 0 <- bubble (valid=0).
  4. otherwise: shift, entry 0 <- {ex_valid_i, ex_reg_write_i, ex_is_load_i, ex_rd_i}.
  - Entry DEPTH-1 is discarded on each shift.
- Counter:
  - stall_cnt increments when stall_o & !hold_i.
  - Saturates at all-ones; never wraps.
- Reset values: fwd_sel_o=0, stall_o=0, stall_cnt_o=0 (follow from empty tracker).
- Latency:
  - Selects and stall are same-cycle combinational from inputs and tracker state.
  - Tracker state lags EX by one cycle.
- Load-use sequence (LOAD_LAT=L): a dependent instruction immediately after a load stalls for exactly L cycles, then forwards with sel = L+1.
- Reset mid-operation clears all in-flight tracking; the first post-reset instruction sees no forwarding.
- rd = 0 is never forwarded or stalled on, even when wr = 1.

Decomposition:
- Shared package: fwd_sel encoding constants (FWD_REGFILE = 0, FWD_STAGE_BASE = 1), the entry struct/field layout, and the parameter legality check.
- One natural sub-module, fwd_match_prio: for one source, a priority-encode across DEPTH entries returning select and hazard. Instantiate NUM_SRC times with a generate loop.
- Tracker and counter live in the top.

Test Plan:
- Reset, then EX add x5,x1,x2 with no prior writes -> fwd_sel = {0,0}, stall_o = 0, stall_cnt_o = 0.
- add x3 then next cycle sub x4,x3,x3 (DEPTH=3) -> both sels = 1, no stall. Insert one unrelated instruction between them -> sels = 2.
- lw x7 then add x8,x7,x0 with LOAD_LAT=1:
  - cycle 1: stall_o = 1, stall_cnt_o increments to 1.
  - next cycle: source0 sel = 2, stall_o = 0.
  - Rerun with LOAD_LAT=2 -> 2 stall cycles, then sel = 3.
- Same rd in entries 0 and 2 (x9 written twice) with EX reads x9 -> sel = 1 (youngest wins). Repeat with rd = x0, wr = 1 -> sel = 0.
- hold_i = 1 for 3 cycles while a load hazard is pending:
  - entries frozen, stall_o stays 1, stall_cnt_o unchanged.
  - after release: stall resolves after LOAD_LAT non-held cycles.
- flush_i = 1 with EX writing x6 -> the next instruction reading x6 gets sel = 0 from bubble entry 0. rst asserted mid-stream -> all sels 0 the following cycle.
- Additionally: force stall_cnt to saturation (CNT_W = 4, 20 stall cycles) -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/fwd_hazard_unit_p_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_p_pkg
//   Shared definitions for the parametrised forwarding / load-use hazard unit:
//   forward-select encoding, the layout of one in-flight write tracker entry,
//   and the elaboration-time parameter legality check.
//
//   Tracker entry layout (packed, LSB first):
//     [ENT_FLAGS_W-1:0]              ent_flags_t {valid, wr, is_load}
//     [ENT_FLAGS_W +: REG_AW]        rd
// -----------------------------------------------------------------------------
package fwd_hazard_unit_p_pkg;

    // Forward select encoding: 0 reads the register file, k+1 takes entry k.
    localparam int FWD_REGFILE    = 0;
    localparam int FWD_STAGE_BASE = 1;

    // Per-entry control flags; valid is the MSB of the flag group.
    typedef struct packed {
        logic valid;
        logic wr;
        logic is_load;
    } ent_flags_t;

    localparam int ENT_FLAGS_W = $bits(ent_flags_t);

    function automatic int ent_width(input int reg_aw);
        return reg_aw + ENT_FLAGS_W;
    endfunction

    // Load data becomes forwardable LOAD_LAT cycles after EX/MEM, so it must
    // still be inside the tracker at that point.
    function automatic bit params_legal(input int reg_aw, input int num_src,
                                        input int depth, input int load_lat,
                                        input int cnt_w, input int sel_w);
        return (reg_aw >= 1) && (num_src >= 1) && (depth >= 1) &&
               (load_lat >= 0) && (load_lat < depth) && (cnt_w >= 1) &&
               (sel_w >= $clog2(depth + 1));
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_p_match.sv
// -----------------------------------------------------------------------------
// fwd_match_prio
//   Priority encoder for one EX source operand across all DEPTH tracker
//   entries. The youngest (lowest index) matching entry wins; its index drives
//   the forward select and, if it is a load that is still too young to have
//   data, raises hazard_o.
//
//   Ports:
//     ent_i       in   DEPTH packed tracker entries, entry k at [k*ENT_W +: ENT_W]
//     rs_i        in   source register address
//     rs_used_i   in   source is actually read (0 for immediate operands)
//     ex_valid_i  in   EX holds a real instruction
//     sel_o       out  0 = register file, k+1 = entry k
//     hazard_o    out  winning entry is a load not yet forwardable
// -----------------------------------------------------------------------------
module fwd_match_prio
    import fwd_hazard_unit_p_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH*(REG_AW+ENT_FLAGS_W)-1:0] ent_i,
    input  logic [REG_AW-1:0]                     rs_i,
    input  logic                                  rs_used_i,
    input  logic                                  ex_valid_i,
    output logic [SEL_W-1:0]                      sel_o,
    output logic                                  hazard_o
);

    localparam int ENT_W = REG_AW + ENT_FLAGS_W;

    logic [ENT_W-1:0]  ent;
    ent_flags_t        flags;
    logic [REG_AW-1:0] rd;
    logic [SEL_W-1:0]  sel;
    logic              hit_hazard;

    always_comb begin
        sel        = SEL_W'(FWD_REGFILE);
        hit_hazard = 1'b0;
        ent        = '0;
        flags      = '0;
        rd         = '0;
        // Walk oldest to youngest so a younger match overwrites an older one.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ent   = ent_i[k*ENT_W +: ENT_W];
            flags = ent_flags_t'(ent[ENT_FLAGS_W-1:0]);
            rd    = ent[ENT_FLAGS_W +: REG_AW];
            // x0 is hard-wired zero: never forward from or stall on it.
            if (flags.valid && flags.wr && (rd != '0) && (rd == rs_i) && rs_used_i) begin
                sel        = SEL_W'(k + FWD_STAGE_BASE);
                hit_hazard = flags.is_load && (k < LOAD_LAT);
            end
        end
    end

    assign sel_o    = ex_valid_i ? sel : SEL_W'(FWD_REGFILE);
    assign hazard_o = hit_hazard;

endmodule

// File: rtl/fwd_hazard_unit_p.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_p
//   Forwarding and load-use hazard unit beside the EX stage. In-flight register
//   writes are tracked internally in a DEPTH-entry shift register (entry 0 =
//   EX/MEM, entry DEPTH-1 = oldest), so no per-stage rd inputs are needed.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     ex_valid_i       EX holds a real instruction
//     ex_reg_write_i   EX instruction writes rd
//     ex_is_load_i     EX instruction is a load
//     ex_rd_i          EX destination register
//     ex_rs_i          EX sources, source j at [j*REG_AW +: REG_AW]
//     ex_rs_used_i     per-source "read from regfile" flag
//     hold_i           global freeze: tracker and counter keep their state
//     flush_i          EX instruction killed; it enters the tracker as a bubble
//     fwd_sel_o        per-source select, 0 = regfile, k+1 = entry k
//     stall_o          load-use hazard this cycle
//     stall_cnt_o      saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit_p
    import fwd_hazard_unit_p_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid_i,
    input  logic                       ex_reg_write_i,
    input  logic                       ex_is_load_i,
    input  logic [REG_AW-1:0]          ex_rd_i,
    input  logic [NUM_SRC*REG_AW-1:0]  ex_rs_i,
    input  logic [NUM_SRC-1:0]         ex_rs_used_i,
    input  logic                       hold_i,
    input  logic                       flush_i,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
    output logic                       stall_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    localparam int ENT_W = ent_width(REG_AW);

    generate
        if (!params_legal(REG_AW, NUM_SRC, DEPTH, LOAD_LAT, CNT_W, SEL_W)) begin : g_bad_params
            $error("fwd_hazard_unit_p: illegal parameters (need LOAD_LAT < DEPTH, DEPTH >= 1)");
        end
    endgenerate

    logic [ENT_W-1:0]       ent_q [DEPTH];
    logic [ENT_W-1:0]       ent_d [DEPTH];
    logic [DEPTH*ENT_W-1:0] ent_flat;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [NUM_SRC-1:0]     hazard_vec;
    ent_flags_t             ex_flags;

    always_comb begin
        ent_flat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_flat[k*ENT_W +: ENT_W] = ent_q[k];
        end
    end

    // Per-source priority match across the tracker.
    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        fwd_match_prio #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_match (
            .ent_i      (ent_flat),
            .rs_i       (ex_rs_i[j*REG_AW +: REG_AW]),
            .rs_used_i  (ex_rs_used_i[j]),
            .ex_valid_i (ex_valid_i),
            .sel_o      (fwd_sel_o[j*SEL_W +: SEL_W]),
            .hazard_o   (hazard_vec[j])
        );
    end

    assign stall_o = (|hazard_vec) && ex_valid_i && !flush_i;

    // A stalled or flushed EX instruction is replaced by a bubble so it is not
    // seen as a producer; a stalled one is re-presented next cycle.
    always_comb begin
        ex_flags.valid   = ex_valid_i;
        ex_flags.wr      = ex_reg_write_i;
        ex_flags.is_load = ex_is_load_i;
        ent_d[0] = (flush_i || stall_o) ? '0 : {ex_rd_i, ex_flags};
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            cnt_q <= '0;
        end else if (!hold_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit_p.sv
module tb_fwd_hazard_unit_p;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int D  = 3;
    localparam int LL = 2;
    localparam int CW = 4;
    localparam int SW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ex_valid = 1'b0;
    logic           ex_wr = 1'b0;
    logic           ex_ld = 1'b0;
    logic [AW-1:0]  ex_rd = '0;
    logic [NS*AW-1:0] ex_rs = '0;
    logic [NS-1:0]  ex_used = '0;
    logic           hold = 1'b0;
    logic           flush = 1'b0;
    logic [NS*SW-1:0] fwd_sel;
    logic           stall;
    logic [CW-1:0]  stall_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit_p #(
        .REG_AW(AW), .NUM_SRC(NS), .DEPTH(D), .LOAD_LAT(LL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_reg_write_i(ex_wr), .ex_is_load_i(ex_ld),
        .ex_rd_i(ex_rd), .ex_rs_i(ex_rs), .ex_rs_used_i(ex_used),
        .hold_i(hold), .flush_i(flush),
        .fwd_sel_o(fwd_sel), .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    // Reference model: history of instructions that left EX, youngest first.
    typedef struct {
        logic          v;
        logic          wr;
        logic          ld;
        logic [AW-1:0] rd;
    } rec_t;

    typedef struct {
        logic [NS*SW-1:0] sel;
        logic             stall;
        logic [CW-1:0]    cnt;
        string            tag;
    } exp_t;

    rec_t hist[$];
    exp_t sbq[$];
    int   m_cnt = 0;
    int   n_tot = 0;
    int   n_pass = 0;
    bit   stim_done = 0;

    task automatic cmp(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s/%s: got %0h expected %0h", tag, what, act, exp);
        else
            n_pass++;
    endtask

    task automatic ins(input logic v, input logic w, input logic l, input int rd,
                       input int r0, input int r1, input logic [1:0] u);
        ex_valid = v; ex_wr = w; ex_ld = l; ex_rd = AW'(rd);
        ex_rs = {AW'(r1), AW'(r0)}; ex_used = u;
    endtask

    // Called at a negedge with inputs already driven: predicts this cycle's
    // outputs, queues them, then advances the model across the next posedge.
    task automatic cyc(input string tag, input bit chk);
        exp_t e;
        rec_t r;
        bit   hz;
        int   w;
        e.sel = '0; e.tag = tag; hz = 0;
        for (int j = 0; j < NS; j++) begin
            w = -1;
            if (ex_used[j])
                for (int k = 0; k < hist.size() && w < 0; k++)
                    if (hist[k].v && hist[k].wr && hist[k].rd != 0 &&
                        hist[k].rd == ex_rs[j*AW +: AW]) w = k;
            if (w >= 0 && ex_valid) begin
                e.sel[j*SW +: SW] = SW'(w + 1);
                if (hist[w].ld && w < LL) hz = 1;
            end
        end
        e.stall = hz && ex_valid && !flush;
        e.cnt   = CW'(m_cnt);
        if (chk) sbq.push_back(e);
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_cnt = 0;
        end else if (!hold) begin
            if (flush || e.stall) begin
                r.v = 0; r.wr = 0; r.ld = 0; r.rd = '0;
            end else begin
                r.v = ex_valid; r.wr = ex_wr; r.ld = ex_ld; r.rd = ex_rd;
            end
            hist.push_front(r);
            if (hist.size() > D) void'(hist.pop_back());
            if (e.stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(negedge clk);
    endtask

    // Monitor: outputs are presented every cycle; compare one queued
    // expectation per cycle, sampled mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp(e.tag, "fwd_sel", 32'(fwd_sel), 32'(e.sel));
                cmp(e.tag, "stall", 32'(stall), 32'(e.stall));
                cmp(e.tag, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        rst = 1; ins(0, 0, 0, 0, 0, 0, 2'b00);
        cyc("reset0", 0);
        cyc("reset1", 1);
        rst = 0;

        ins(1, 1, 0, 5, 1, 2, 2'b11);  cyc("nofwd", 1);

        ins(1, 1, 0, 3, 1, 2, 2'b11);  cyc("add_x3", 1);
        ins(1, 1, 0, 4, 3, 3, 2'b11);  cyc("fwd_sel1", 1);
        ins(1, 1, 0, 3, 1, 2, 2'b11);  cyc("add_x3b", 1);
        ins(1, 1, 0, 12, 13, 14, 2'b11); cyc("unrelated", 1);
        ins(1, 1, 0, 4, 3, 3, 2'b11);  cyc("fwd_sel2", 1);

        ins(1, 1, 1, 7, 1, 0, 2'b01);  cyc("lw_x7", 1);
        for (int i = 0; i <= LL; i++) begin
            ins(1, 1, 0, 8, 7, 0, 2'b11); cyc("load_use", 1);
        end

        ins(1, 1, 0, 9, 1, 1, 2'b11);  cyc("x9_old", 1);
        ins(1, 1, 0, 10, 1, 1, 2'b11); cyc("x10", 1);
        ins(1, 1, 0, 9, 1, 1, 2'b11);  cyc("x9_new", 1);
        ins(1, 0, 0, 0, 9, 9, 2'b11);  cyc("youngest", 1);
        ins(1, 1, 0, 0, 1, 1, 2'b11);  cyc("x0_a", 1);
        ins(1, 1, 0, 0, 1, 1, 2'b11);  cyc("x0_b", 1);
        ins(1, 0, 0, 0, 0, 0, 2'b11);  cyc("x0_read", 1);

        ins(1, 1, 1, 7, 1, 0, 2'b01);  cyc("lw_hold", 1);
        ins(1, 1, 0, 8, 7, 7, 2'b11);
        hold = 1;
        for (int i = 0; i < 3; i++) cyc("held", 1);
        hold = 0;
        for (int i = 0; i <= LL; i++) cyc("released", 1);

        ins(1, 1, 0, 6, 1, 2, 2'b11); flush = 1; cyc("flush_x6", 1);
        flush = 0;
        ins(1, 1, 0, 4, 6, 6, 2'b11); cyc("after_flush", 1);

        ins(1, 1, 0, 11, 1, 2, 2'b11); cyc("x11", 1);
        rst = 1; ins(1, 1, 0, 11, 1, 2, 2'b11); cyc("mid_rst", 1);
        rst = 0; ins(1, 1, 0, 4, 11, 11, 2'b11); cyc("post_rst", 1);

        for (int n = 0; n < 10; n++) begin
            ins(1, 1, 1, 7, 1, 0, 2'b01); cyc("sat_lw", 1);
            for (int i = 0; i <= LL; i++) begin
                ins(1, 1, 0, 8, 0, 7, 2'b10); cyc("sat_use", 1);
            end
        end

        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            hold  = ($urandom_range(0, 99) < 10);
            flush = ($urandom_range(0, 99) < 8);
            ins($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 30, $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
            cyc("random", 1);
        end
        rst = 0; hold = 0; flush = 0;

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_tot++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
